// File: rtl/dot_prod_unit_if.sv
// ============================================================================
// dot_prod_unit_if : weight-load / vector-in / result-out bundle for dot_prod_unit
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface dot_prod_unit_if #(
  parameter int NROW = 16,
  parameter int NCOL = 4,
  parameter int QN   = 6,
  parameter int QM   = 11
);
  localparam int BITWIDTH        = QN + QM + 1;
  localparam int MEMORY_BITWIDTH = BITWIDTH * NROW;
  localparam int ADDR_BITWIDTH   = $clog2(NCOL);

  logic                       writeEn;
  logic [ADDR_BITWIDTH-1:0]   colAddressWrite;
  logic [MEMORY_BITWIDTH-1:0] weightMemInput;
  logic [BITWIDTH-1:0]        inputVec;
  logic [ADDR_BITWIDTH-1:0]   colAddressRead;
  logic                       dataReady;
  logic [MEMORY_BITWIDTH-1:0] outputVec;

  modport master (
    output writeEn, colAddressWrite, weightMemInput, inputVec,
    input  colAddressRead, dataReady, outputVec
  );

  modport slave (
    input  writeEn, colAddressWrite, weightMemInput, inputVec,
    output colAddressRead, dataReady, outputVec
  );
endinterface

`default_nettype wire

// File: rtl/dot_prod_unit.sv
// ============================================================================
// dot_prod_unit : column-serial fixed-point y = W*x, NROW parallel MAC lanes
// Optional macro SATURATE_EN : clamp results instead of two's-complement wrap
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module dot_prod_unit #(
  parameter int NROW          = 16,
  parameter int NCOL          = 4,
  parameter int QN            = 6,
  parameter int QM            = 11,
  parameter int DSP48_PER_ROW = 4
) (
  input  wire logic      clock,
  input  wire logic      reset,
  dot_prod_unit_if.slave bus
);
  localparam int BITWIDTH        = QN + QM + 1;
  localparam int MEMORY_BITWIDTH = BITWIDTH * NROW;
  localparam int ADDR_BITWIDTH   = $clog2(NCOL);
  localparam int ACC_W           = BITWIDTH + ADDR_BITWIDTH + 1;
  localparam int PROD_W          = 2 * BITWIDTH;
  localparam int D               = DSP48_PER_ROW;

  localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX  = ACC_W'((64'sd1 <<< (BITWIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0]  SAT_MIN  = ~SAT_MAX;

  // Weight RAM is deliberately outside the reset domain so it can be loaded during reset
  logic [MEMORY_BITWIDTH-1:0] mem [NCOL];

  always_ff @(posedge clock) begin
    if (bus.writeEn) begin
      mem[bus.colAddressWrite] <= bus.weightMemInput;
    end
  end

  logic [ADDR_BITWIDTH-1:0]   col_q, col_d;
  logic                       done_q, done_d;
  logic [D-1:0]               vld_q, vld_d;
  logic [D-1:0]               last_q, last_d;
  logic signed [ACC_W-1:0]    pipe_q [D][NROW];
  logic signed [ACC_W-1:0]    pipe_d [D][NROW];
  logic signed [ACC_W-1:0]    acc_q [NROW];
  logic signed [ACC_W-1:0]    acc_d [NROW];
  logic                       ready_q, ready_d;
  logic [MEMORY_BITWIDTH-1:0] out_q, out_d;

  logic [MEMORY_BITWIDTH-1:0] w_col;
  logic signed [BITWIDTH-1:0] x_s;
  logic signed [ACC_W-1:0]    prod_sh [NROW];

  assign w_col = mem[col_q];
  assign x_s   = bus.inputVec;

  generate
    for (genvar r = 0; r < NROW; r++) begin : g_row
      logic signed [BITWIDTH-1:0] w_r;
      logic signed [PROD_W-1:0]   prod;
      assign w_r        = w_col[r*BITWIDTH +: BITWIDTH];
      assign prod       = w_r * x_s;
      // Arithmetic shift floors toward -inf; the cast wraps into accumulator width
      assign prod_sh[r] = ACC_W'(prod >>> QM);
    end
  endgenerate

  function automatic logic [BITWIDTH-1:0] narrow(input logic signed [ACC_W-1:0] a);
`ifdef SATURATE_EN
    if (a > SAT_MAX) begin
      return SAT_MAX[BITWIDTH-1:0];
    end else if (a < SAT_MIN) begin
      return SAT_MIN[BITWIDTH-1:0];
    end else begin
      return a[BITWIDTH-1:0];
    end
`else
    return a[BITWIDTH-1:0];
`endif
  endfunction

  always_comb begin
    col_d   = col_q;
    done_d  = done_q;
    vld_d   = vld_q;
    last_d  = last_q;
    pipe_d  = pipe_q;
    acc_d   = acc_q;
    ready_d = ready_q;
    out_d   = out_q;

    if (!done_q) begin
      if (col_q == LAST_COL) begin
        done_d = 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    vld_d[0]  = !done_q;
    last_d[0] = !done_q && (col_q == LAST_COL);
    for (int r = 0; r < NROW; r++) begin
      pipe_d[0][r] = prod_sh[r];
    end
    for (int s = 1; s < D; s++) begin
      vld_d[s]  = vld_q[s-1];
      last_d[s] = last_q[s-1];
      for (int r = 0; r < NROW; r++) begin
        pipe_d[s][r] = pipe_q[s-1][r];
      end
    end

    if (vld_q[D-1]) begin
      for (int r = 0; r < NROW; r++) begin
        acc_d[r] = acc_q[r] + pipe_q[D-1][r];
      end
    end

    // Result and ready are published on the same edge the final product lands
    if (vld_q[D-1] && last_q[D-1]) begin
      ready_d = 1'b1;
      for (int r = 0; r < NROW; r++) begin
        out_d[r*BITWIDTH +: BITWIDTH] = narrow(acc_d[r]);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      done_q  <= 1'b0;
      vld_q   <= '0;
      last_q  <= '0;
      ready_q <= 1'b0;
      out_q   <= '0;
      for (int s = 0; s < D; s++) begin
        for (int r = 0; r < NROW; r++) begin
          pipe_q[s][r] <= '0;
        end
      end
      for (int r = 0; r < NROW; r++) begin
        acc_q[r] <= '0;
      end
    end else begin
      col_q   <= col_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      pipe_q  <= pipe_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.colAddressRead = col_q;
  assign bus.dataReady      = ready_q;
  assign bus.outputVec      = out_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_prod_unit.sv
// ============================================================================
// tb_dot_prod_unit : directed vectors, queue scoreboard checked on dataReady rise
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_dot_prod_unit;
  localparam int NROW = 16;
  localparam int NCOL = 4;
  localparam int BW   = 18;
  localparam int D    = 4;
  localparam int MW   = BW * NROW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dot_prod_unit_if bus ();

  dot_prod_unit #(
    .NROW(NROW), .NCOL(NCOL), .QN(6), .QM(11), .DSP48_PER_ROW(D)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;
  logic [MW-1:0] exp_q [$];

  logic [MW-1:0] wcol [NCOL];
  logic [BW-1:0] xv   [NCOL];

  // Posedges since reset release, used to check result latency
  int cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises dataReady
  logic prev_rdy = 1'b0;
  logic [MW-1:0] mon_exp;
  always @(negedge clock) begin
    if (bus.dataReady && !prev_rdy) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_ready: got outputVec %h with empty scoreboard", bus.outputVec);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", bus.outputVec, mon_exp);
      end
      check("latency", MW'(cyc), MW'(NCOL + D));
    end
    prev_rdy = bus.dataReady;
  end

  function automatic logic [MW-1:0] fill(input logic [BW-1:0] v);
    return {NROW{v}};
  endfunction

  task automatic load_weights();
    for (int c = 0; c < NCOL; c++) begin
      bus.writeEn         = 1'b1;
      bus.colAddressWrite = 2'(c);
      bus.weightMemInput  = wcol[c];
      @(negedge clock);
    end
    bus.writeEn = 1'b0;
  endtask

  task automatic reset_and_load();
    @(negedge clock);
    reset = 1'b1;
    load_weights();
    check("rst_ready", MW'(bus.dataReady), '0);
    check("rst_out", bus.outputVec, '0);
    check("rst_col", MW'(bus.colAddressRead), '0);
  endtask

  // One full sample; poke rewrites already-consumed column 0 mid-run
  task automatic run(input logic [MW-1:0] e, input logic poke);
    int n;
    reset_and_load();
    exp_q.push_back(e);
    reset = 1'b0;
    n = 0;
    while (!bus.dataReady && n < 20) begin
      bus.inputVec = xv[bus.colAddressRead];
      if (poke && bus.colAddressRead == 2'd2) begin
        bus.writeEn         = 1'b1;
        bus.colAddressWrite = 2'd0;
        bus.weightMemInput  = '0;
      end else begin
        bus.writeEn = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    bus.writeEn = 1'b0;
    if (!bus.dataReady) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: dataReady %0d after %0d cycles, required 1", bus.dataReady, n);
    end else begin
      repeat (3) @(negedge clock);
      check("hold_out", bus.outputVec, e);
      check("hold_ready", MW'(bus.dataReady), MW'(1));
      check("hold_col", MW'(bus.colAddressRead), MW'(NCOL - 1));
    end
  endtask

  task automatic run_abort();
    int n;
    reset_and_load();
    reset = 1'b0;
    n = 0;
    while (bus.colAddressRead != 2'd2 && n < 10) begin
      bus.inputVec = xv[bus.colAddressRead];
      @(negedge clock);
      n++;
    end
    bus.inputVec = xv[bus.colAddressRead];
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_ready", MW'(bus.dataReady), '0);
    check("abort_out", bus.outputVec, '0);
    check("abort_col", MW'(bus.colAddressRead), '0);
  endtask

  logic [MW-1:0] e;
  logic [BW-1:0] wv;

  initial begin
    bus.writeEn         = 1'b0;
    bus.colAddressWrite = '0;
    bus.weightMemInput  = '0;
    bus.inputVec        = '0;

    #1;
    check("por_ready", MW'(bus.dataReady), '0);
    check("por_out", bus.outputVec, '0);

    // W = 1.0 everywhere, x = 1,2,3,4 -> 10.0 per row
    for (int c = 0; c < NCOL; c++) begin
      wcol[c] = fill(18'h00800);
      xv[c]   = 18'(2048 * (c + 1));
    end
    run(fill(18'h05000), 1'b1);

    // Row0 W = -1.5, x = 2.0 -> -12.0; other rows zero
    for (int c = 0; c < NCOL; c++) begin
      wcol[c] = MW'(18'h3F400);
      xv[c]   = 18'h01000;
    end
    run(MW'(18'h3A000), 1'b0);

    // 63.0 * 63.0: accumulator wraps in 21 bits to 0x102000
    for (int c = 0; c < NCOL; c++) begin
      wcol[c] = fill(18'h1F800);
      xv[c]   = 18'h1F800;
    end
`ifdef SATURATE_EN
    run(fill(18'h20000), 1'b0);
`else
    run(fill(18'h02000), 1'b0);
`endif

    // Fraction and sign: 0.5*-0.5, +1lsb*-0.5 floors to -1lsb, -1lsb*-0.5 floors to 0
    for (int c = 0; c < NCOL; c++) begin
      wcol[c] = '0;
      wcol[c][0*BW +: BW] = 18'h00400;
      wcol[c][1*BW +: BW] = 18'h00001;
      wcol[c][2*BW +: BW] = 18'h3FFFF;
      xv[c] = 18'h3FC00;
    end
    e = '0;
    e[0*BW +: BW] = 18'h3F800;
    e[1*BW +: BW] = 18'h3FFFC;
    run(e, 1'b0);

    // Abort at column 2, then a clean run of the first vector
    for (int c = 0; c < NCOL; c++) begin
      wcol[c] = fill(18'h00800);
      xv[c]   = 18'(2048 * (c + 1));
    end
    run_abort();
    run(fill(18'h05000), 1'b0);

    // Back-to-back samples: W[r] = (r+1)*0.125*s, x[c] = +/-(c+1) -> y[r] = +/-1.25*(r+1)*s
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < NCOL; c++) begin
        for (int r = 0; r < NROW; r++) begin
          wv = 18'((r + 1) * 256 * (k / 2 + 1));
          wcol[c][r*BW +: BW] = wv;
        end
        xv[c] = (k % 2 == 0) ? 18'(2048 * (c + 1)) : 18'(-2048 * (c + 1));
      end
      for (int r = 0; r < NROW; r++) begin
        e[r*BW +: BW] = (k % 2 == 0) ? 18'(2560 * (r + 1) * (k / 2 + 1))
                                     : 18'(-2560 * (r + 1) * (k / 2 + 1));
      end
      run(e, 1'b0);
    end

    @(negedge clock);
    check("scoreboard_empty", MW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
